// File: rtl/core6502_pkg.sv
// Shared 6502 core definitions: BRK injection source encodings, the BRK opcode
// and the default instruction length limit used by the fetch sequencer.
package core6502_pkg;

    typedef enum logic [1:0] {
        BRK_NONE  = 2'b00,
        BRK_IRQ   = 2'b01,
        BRK_NMI   = 2'b10,
        BRK_RESET = 2'b11
    } brk_src_e;

    localparam logic [7:0]  OPC_BRK       = 8'h00;
    localparam int unsigned MAX_T_DEFAULT = 6;

    // Interrupt arbitration at T1 entry: reset beats NMI beats unmasked IRQ.
    function automatic brk_src_e select_brk_src(input logic rst_pend,
                                                input logic nmi_pend,
                                                input logic irq_req);
        brk_src_e src;
        src = BRK_NONE;
        if (rst_pend) begin
            src = BRK_RESET;
        end else if (nmi_pend) begin
            src = BRK_NMI;
        end else if (irq_req) begin
            src = BRK_IRQ;
        end
        return src;
    endfunction

endpackage

// File: rtl/fetch_seq_if.sv
// Bus between the fetch sequencer (slave) and the rest of the core (master):
// cycle control, interrupt pins, IR byte path and timing state outputs.
interface fetch_seq_if
    import core6502_pkg::*;
#(
    parameter int unsigned MAX_T = MAX_T_DEFAULT
) ();

    logic             RDY;
    logic [7:0]       PD;
    logic             TRES;
    logic             n_NMI;
    logic             n_IRQ;
    logic             I_FLAG;

    logic [7:0]       n_PD_IR;
    logic             FETCH;
    logic             SYNC;
    logic [MAX_T-1:0] T;
    logic             PC_INC;
    logic [1:0]       BRK_SRC;
    logic             JAM;

    modport master (
        output RDY, PD, TRES, n_NMI, n_IRQ, I_FLAG,
        input  n_PD_IR, FETCH, SYNC, T, PC_INC, BRK_SRC, JAM
    );

    modport slave (
        input  RDY, PD, TRES, n_NMI, n_IRQ, I_FLAG,
        output n_PD_IR, FETCH, SYNC, T, PC_INC, BRK_SRC, JAM
    );

endinterface

// File: rtl/nmi_edge_det.sv
// Falling-edge detector for the NMI pin with a pending latch; a new edge in
// the same cycle as the clear keeps the request pending.
module nmi_edge_det (
    input  logic phi0_i,
    input  logic n_res_i,
    input  logic n_nmi_i,
    input  logic clear_i,
    output logic pend_o
);

    logic nmi_prev_q, nmi_prev_d;
    logic nmi_pend_q, nmi_pend_d;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        nmi_prev_d = n_nmi_i;
        nmi_pend_d = nmi_pend_q;
        if (clear_i) begin
            nmi_pend_d = 1'b0;
        end
        if (nmi_prev_q && !n_nmi_i) begin
            nmi_pend_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge phi0_i) begin
        if (!n_res_i) begin
            nmi_prev_q <= 1'b1;
            nmi_pend_q <= 1'b0;
        end else begin
            nmi_prev_q <= nmi_prev_d;
            nmi_pend_q <= nmi_pend_d;
        end
    end

    assign pend_o = nmi_pend_q;

endmodule

// File: rtl/fetch_seq.sv
// 6502 timing and fetch sequencer: T-state ring, SYNC/FETCH generation,
// BRK injection for reset/NMI/IRQ, and jam detection for runaway instructions.
module fetch_seq
    import core6502_pkg::*;
#(
    parameter int unsigned MAX_T        = MAX_T_DEFAULT,
    parameter bit          RESET_INJECT = 1'b1
) (
    input  logic       PHI0,
    input  logic       n_RES,
    fetch_seq_if.slave bus
);

    localparam logic [MAX_T-1:0] T_1    = MAX_T'(1);
    localparam logic [MAX_T-1:0] T_2    = MAX_T'(2);
    localparam logic [MAX_T-1:0] T_NONE = '0;

    localparam brk_src_e RESET_SRC = RESET_INJECT ? BRK_RESET : BRK_NONE;

    logic [MAX_T-1:0] t_q, t_d;
    logic             jam_q, jam_d;
    logic             inj_q, inj_d;
    logic             rst_pend_q, rst_pend_d;
    brk_src_e         brk_src_q, brk_src_d;

    logic in_t1;
    logic sync;
    logic fetch;
    logic nmi_pend;
    logic nmi_clear;

    assign in_t1     = t_q[0];
    assign sync      = in_t1 & ~jam_q & n_RES;
    assign fetch     = sync & bus.RDY;
    assign nmi_clear = fetch && (brk_src_q == BRK_NMI);

    nmi_edge_det u_nmi_edge_det (
        .phi0_i  (PHI0),
        .n_res_i (n_RES),
        .n_nmi_i (bus.n_NMI),
        .clear_i (nmi_clear),
        .pend_o  (nmi_pend)
    );

    always_comb begin
        t_d        = t_q;
        jam_d      = jam_q;
        inj_d      = inj_q;
        brk_src_d  = brk_src_q;
        rst_pend_d = rst_pend_q;

        if (fetch && (brk_src_q == BRK_RESET)) begin
            rst_pend_d = 1'b0;
        end

        if (bus.RDY && !jam_q) begin
            if (in_t1) begin
                t_d = T_2;
            end else if (bus.TRES) begin
                t_d       = T_1;
                // Injection is decided only here, so IRQ is sampled, not latched.
                brk_src_d = select_brk_src(rst_pend_q, nmi_pend,
                                           ~bus.n_IRQ & ~bus.I_FLAG);
                inj_d     = (brk_src_d != BRK_NONE);
            end else if (t_q[MAX_T-1]) begin
                jam_d = 1'b1;
                t_d   = T_NONE;
            end else begin
                t_d = t_q << 1;
            end
        end
    end

    always_ff @(posedge PHI0) begin
        if (!n_RES) begin
            t_q        <= T_1;
            jam_q      <= 1'b0;
            inj_q      <= RESET_INJECT;
            rst_pend_q <= RESET_INJECT;
            brk_src_q  <= RESET_SRC;
        end else begin
            t_q        <= t_d;
            jam_q      <= jam_d;
            inj_q      <= inj_d;
            rst_pend_q <= rst_pend_d;
            brk_src_q  <= brk_src_d;
        end
    end

    always_comb begin
        bus.n_PD_IR = ~bus.PD;
        if (!n_RES) begin
            bus.n_PD_IR = 8'hFF;
        end else if (in_t1 && inj_q) begin
            bus.n_PD_IR = ~OPC_BRK;
        end
    end

    assign bus.SYNC    = sync;
    assign bus.FETCH   = fetch;
    assign bus.T       = t_q;
    assign bus.PC_INC  = fetch & ~inj_q;
    assign bus.BRK_SRC = brk_src_q;
    assign bus.JAM     = jam_q;

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Timing and fetch sequencer for the 6502 core's instruction register.
- Owns the T-state ring (T1..T6) and produces SYNC and FETCH, the load enable of the IR latch.
- Selects what the IR captures: the opcode byte from the data bus, or a forced BRK (0x00) for reset, NMI or IRQ injection.
- Detects runaway instructions and jams the core.

Parameters:
- MAX_T, 6: highest T-state an instruction may reach. Reaching it without TRES raises JAM.
- RESET_INJECT, 1: 1 = first fetch after reset is an injected BRK with source RESET; 0 = normal fetch.

Ports:
- PHI0  in  1  core clock, rising-edge; all state updates on it.
- n_RES  in  1  reset, synchronous, active-low.
- RDY  in  1  1 = bus cycle completes; 0 = stall.
- PD  in  8  opcode byte from the data bus/predecode.
- TRES  in  1  from decode: current cycle is the instruction's last; next cycle is T1.
- n_NMI  in  1  NMI pin, active-low, falling-edge sensitive.
- n_IRQ  in  1  IRQ pin, active-low, level sensitive.
- I_FLAG  in  1  interrupt-disable flag from the P register.
- n_PD_IR  out  8  inverted byte presented to the IR's n_PD input.
- FETCH  out  1  IR load enable.
- SYNC  out  1  opcode-fetch cycle indicator.
- T  out  MAX_T  one-hot T-state; bit0 = T1.
- PC_INC  out  1  increment PC this cycle (opcode fetch, not injected).
- BRK_SRC  out  2  injection source: 00 none, 01 IRQ, 10 NMI, 11 RESET.
- JAM  out  1  core jammed.

Behaviour:
- Reset (n_RES=0 at edge): T=000001; JAM=0; nmi_pend=0; nmi_prev=1; rst_pend=RESET_INJECT; inj=RESET_INJECT; BRK_SRC=RESET_INJECT?11:00.
- Outputs while reset is held: SYNC=0, FETCH=0, PC_INC=0, n_PD_IR=FF.
- First cycle after release is T1 (SYNC=1).
- Reset asserted mid-instruction: everything reinitialises at the next edge. Injection state is discarded, then re-armed as RESET.
- SYNC = T[0] & ~JAM & n_RES. FETCH = SYNC & RDY. Both combinational from state.
- Injection decision is registered on every edge that moves T into T1, and at reset.
  - Priority: rst_pend > nmi_pend > (~n_IRQ & ~I_FLAG).
  - Sets inj and BRK_SRC; inj=0 gives BRK_SRC=00.
  - Held unchanged through RDY stalls in T1.
- During T1 with inj=1: n_PD_IR=8'hFF (BRK) and PC_INC=0.
- During T1 with inj=0: n_PD_IR=~PD and PC_INC=FETCH.
- Outside T1: n_PD_IR=~PD and PC_INC=0.
- NMI edge detection:
  - nmi_prev<=n_NMI every edge, including stalls and jam.
  - nmi_pend set on nmi_prev=1 & n_NMI=0.
  - nmi_pend cleared on FETCH with BRK_SRC=10. A new edge in the same cycle as the clear wins: pend stays 1.
- rst_pend is cleared on FETCH with BRK_SRC=11.
- IRQ is not latched: it is sampled only at T1 entry.
- T advance happens only when RDY=1 and JAM=0:
  - In T1: always go to T2; TRES is ignored.
  - Else if TRES: go to T1.
  - Else if T[MAX_T-1]: JAM<=1 and T<=0.
  - Else: T shifts left by one.
- RDY=0: T, inj, BRK_SRC and JAM hold; FETCH=0.
- JAM=1: T=0, SYNC/FETCH/PC_INC=0. Only reset exits.

Decomposition:
- Shared package core6502_pkg holds:
  - BRK_SRC encodings BRK_NONE/IRQ/NMI/RESET;
  - OPC_BRK=8'h00;
  - default MAX_T.
- One sub-module, nmi_edge_det, holds nmi_prev/nmi_pend with set-wins-over-clear.
- T ring and injection muxing stay in fetch_seq.

Test Plan:
- Release n_RES with RDY=1 and PD=A9 → cycle1: T=000001, FETCH=1, n_PD_IR=FF, BRK_SRC=11, PC_INC=0; next T1 without pend gives inj=0.
- Normal 2-cycle op: PD=EA in T1, TRES=1 in T2 → T sequence 000001,000010,000001; second T1 has n_PD_IR=15, PC_INC=1.
- n_NMI falls during T3 with I_FLAG=1 and n_IRQ=0 → next T1 BRK_SRC=10, n_PD_IR=FF. The following T1 gives BRK_SRC=01, because IRQ is still low and I_FLAG is forced 0 by the bench.
- RDY=0 for 3 cycles in T1 with an NMI edge during the stall → T holds 000001, FETCH=0, BRK_SRC is unchanged, and nmi_pend is still set after the fetch completes.
- TRES never asserted → after T6 the next edge gives JAM=1, T=000000, SYNC=0; JAM stays 1 until n_RES=0.
- n_RES=0 asserted in T4 → next edge T=000001, JAM=0, BRK_SRC=11.
